// File: rtl/fetch_byte_bridge_pkg.sv
// Shared types and constants for the instruction-fetch byte bridge.
// Build option: NEXT_WORD_PREFETCH_EN selects a two-entry buffer with next-word prefetch;
// when undefined the buffer has a single entry.
package fetch_byte_bridge_pkg;

  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned TAG_W          = ADDR_W - 2;
  localparam int unsigned TMO_W          = 16;

  // addi x0,x0,0
  localparam logic [DATA_W-1:0] NOP_WORD_DEFAULT = 32'h0000_0013;

`ifdef NEXT_WORD_PREFETCH_EN
  localparam int unsigned NUM_ENTRIES = 2;
`else
  localparam int unsigned NUM_ENTRIES = 1;
`endif

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FILL     = 2'd1,
    PREFETCH = 2'd2
  } state_e;

  // One buffered instruction word.
  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/fetch_byte_bridge_if.sv
// Core-side fetch port plus byte-wide memory bus of the fetch bridge.
//   master : the bridge (drives core_rdata/core_busy, mem_req/mem_addr, fetch_err)
//   slave  : core and memory (drive core_addr, mem_rdata/mem_ack)
interface fetch_byte_bridge_if;
  import fetch_byte_bridge_pkg::*;

  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_rdata;
  logic              core_busy;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [BYTE_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              fetch_err;

  modport master (
    input  core_addr, mem_rdata, mem_ack,
    output core_rdata, core_busy, mem_req, mem_addr, fetch_err
  );

  modport slave (
    output core_addr, mem_rdata, mem_ack,
    input  core_rdata, core_busy, mem_req, mem_addr, fetch_err
  );
endinterface

// File: rtl/fetch_byte_bridge_byte_word_assembler.sv
// Collects four little-endian bytes into one word and watches for a stalled byte.
//   clk, rst   : clock, synchronous active-high reset
//   start_i    : begin a new word (byte index and stall counter cleared)
//   active_i   : a byte request is outstanding on the bus
//   ack_i      : memory acknowledges the current byte
//   rdata_i    : byte data
//   idx_o      : byte lane currently requested
//   done_o     : pulse, last byte accepted this cycle (word_o valid)
//   timeout_o  : pulse, TIMEOUT stalled cycles reached on the current byte
//   word_o     : assembled word, current byte in the top lane
module byte_word_assembler
  import fetch_byte_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              active_i,
  input  logic              ack_i,
  input  logic [BYTE_W-1:0] rdata_i,
  output logic [1:0]        idx_o,
  output logic              done_o,
  output logic              timeout_o,
  output logic [DATA_W-1:0] word_o
);

  localparam int unsigned LANE_W   = BYTE_W * (BYTES_PER_WORD - 1);
  localparam logic [1:0]  LAST_IDX = 2'(BYTES_PER_WORD - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic [1:0]        idx_q, idx_d;
  logic [LANE_W-1:0] lanes_q, lanes_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              xfer;

  assign xfer = active_i && ack_i;

  // Lower three bytes shift in from the top; the fourth is taken straight from the bus.
  always_comb begin
    idx_d   = idx_q;
    lanes_d = lanes_q;
    tmo_d   = tmo_q;
    if (start_i) begin
      idx_d = '0;
      tmo_d = '0;
    end else if (xfer) begin
      idx_d   = idx_q + 2'd1;
      lanes_d = {rdata_i, lanes_q[LANE_W-1:BYTE_W]};
      tmo_d   = '0;
    end else if (active_i) begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      lanes_q <= '0;
      tmo_q   <= '0;
    end else begin
      idx_q   <= idx_d;
      lanes_q <= lanes_d;
      tmo_q   <= tmo_d;
    end
  end

  // An ack in the same cycle as the last stalled cycle wins over the timeout.
  assign done_o    = xfer && (idx_q == LAST_IDX);
  assign timeout_o = active_i && !ack_i && (tmo_q == TMO_LAST);
  assign word_o    = {rdata_i, lanes_q};
  assign idx_o     = idx_q;

endmodule

// File: rtl/fetch_byte_bridge.sv
// Instruction-fetch bridge: serves 32-bit fetches from a word buffer, filling it with
// four byte reads on a miss. A stalled byte abandons the fill and returns NOP_WORD.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fetch_byte_bridge_if.master (core_addr/core_rdata/core_busy,
//              mem_req/mem_addr/mem_rdata/mem_ack, sticky fetch_err)
// Build option: NEXT_WORD_PREFETCH_EN adds a second entry and prefetch of the next word.
module fetch_byte_bridge
  import fetch_byte_bridge_pkg::*;
#(
  parameter int unsigned       TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  fetch_byte_bridge_if.master bus
);

  state_e            state_q, state_d;
  logic [TAG_W-1:0]  word_addr_q, word_addr_d;
  logic              sel_q, sel_d;
  logic              mem_req_q, mem_req_d;
  logic              fetch_err_q, fetch_err_d;
  entry_t            ent_q [NUM_ENTRIES];

  logic              ent_we;
  logic              ent_sel;
  entry_t            ent_wdata;

  logic              asm_start;
  logic              asm_done;
  logic              asm_timeout;
  logic [1:0]        asm_idx;
  logic [DATA_W-1:0] asm_word;

  logic [TAG_W-1:0]  core_tag;
  logic              hit;
  logic [DATA_W-1:0] hit_data;
  logic              ack_c;
  logic              unused_addr_lsbs;

`ifdef NEXT_WORD_PREFETCH_EN
  logic              hit_sel;
  logic [TAG_W-1:0]  nxt_tag;
  logic              nxt_held;
  logic              mru_q, mru_d;
`endif

  assign core_tag         = bus.core_addr[ADDR_W-1:2];
  assign unused_addr_lsbs = ^bus.core_addr[1:0];
  assign ack_c            = mem_req_q && bus.mem_ack;

  byte_word_assembler #(.TIMEOUT(TIMEOUT)) u_asm (
    .clk       (clk),
    .rst       (rst),
    .start_i   (asm_start),
    .active_i  (mem_req_q),
    .ack_i     (bus.mem_ack),
    .rdata_i   (bus.mem_rdata),
    .idx_o     (asm_idx),
    .done_o    (asm_done),
    .timeout_o (asm_timeout),
    .word_o    (asm_word)
  );

  // Hit lookup against the buffer, combinational from core_addr.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
`ifdef NEXT_WORD_PREFETCH_EN
    hit_sel  = 1'b0;
`endif
    for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
      if (ent_q[i].valid && (ent_q[i].tag == core_tag)) begin
        hit      = 1'b1;
        hit_data = ent_q[i].data;
`ifdef NEXT_WORD_PREFETCH_EN
        hit_sel  = 1'(i);
`endif
      end
    end
  end

`ifdef NEXT_WORD_PREFETCH_EN
  // Is the word after the current fetch already buffered? Tag wraps at the top of memory.
  assign nxt_tag = core_tag + TAG_W'(1);

  always_comb begin
    nxt_held = 1'b0;
    for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
      if (ent_q[i].valid && (ent_q[i].tag == nxt_tag)) nxt_held = 1'b1;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!hit) state_d = FILL;
`ifdef NEXT_WORD_PREFETCH_EN
        else if (!nxt_held) state_d = PREFETCH;
`endif
      end
      FILL: begin
        if (asm_done || asm_timeout) state_d = IDLE;
      end
      PREFETCH: begin
        // A demand miss yields the bus once the in-flight byte has been acked.
        if ((!hit && ack_c) || asm_done || asm_timeout) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath decode.
  always_comb begin
    mem_req_d   = mem_req_q;
    word_addr_d = word_addr_q;
    sel_d       = sel_q;
    fetch_err_d = fetch_err_q;
    asm_start   = 1'b0;
    ent_we      = 1'b0;
    ent_sel     = sel_q;
    ent_wdata   = '0;
`ifdef NEXT_WORD_PREFETCH_EN
    mru_d       = mru_q;
`endif
    case (state_q)
      IDLE: begin
        if (!hit) begin
          asm_start   = 1'b1;
          mem_req_d   = 1'b1;
          word_addr_d = core_tag;
`ifdef NEXT_WORD_PREFETCH_EN
          sel_d       = !mru_q;
`else
          sel_d       = 1'b0;
`endif
        end
`ifdef NEXT_WORD_PREFETCH_EN
        else if (!nxt_held) begin
          // Prefetch target stays invalid until the whole word has arrived.
          asm_start   = 1'b1;
          mem_req_d   = 1'b1;
          word_addr_d = nxt_tag;
          sel_d       = !hit_sel;
          mru_d       = hit_sel;
          ent_we      = 1'b1;
          ent_sel     = !hit_sel;
          ent_wdata   = '0;
        end
`endif
      end
      FILL: begin
        if (asm_done) begin
          ent_we    = 1'b1;
          ent_wdata = '{valid: 1'b1, tag: word_addr_q, data: asm_word};
          mem_req_d = 1'b0;
`ifdef NEXT_WORD_PREFETCH_EN
          mru_d     = sel_q;
`endif
        end else if (asm_timeout) begin
          ent_we      = 1'b1;
          ent_wdata   = '{valid: 1'b1, tag: word_addr_q, data: NOP_WORD};
          fetch_err_d = 1'b1;
          mem_req_d   = 1'b0;
`ifdef NEXT_WORD_PREFETCH_EN
          mru_d       = sel_q;
`endif
        end
      end
      PREFETCH: begin
        if (!hit && ack_c) begin
          mem_req_d = 1'b0;
        end else if (asm_done) begin
          ent_we    = 1'b1;
          ent_wdata = '{valid: 1'b1, tag: word_addr_q, data: asm_word};
          mem_req_d = 1'b0;
        end else if (asm_timeout) begin
          mem_req_d = 1'b0;
        end
      end
      default: mem_req_d = 1'b0;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_addr_q <= '0;
      sel_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      fetch_err_q <= 1'b0;
`ifdef NEXT_WORD_PREFETCH_EN
      mru_q       <= 1'b0;
`endif
    end else begin
      word_addr_q <= word_addr_d;
      sel_q       <= sel_d;
      mem_req_q   <= mem_req_d;
      fetch_err_q <= fetch_err_d;
`ifdef NEXT_WORD_PREFETCH_EN
      mru_q       <= mru_d;
`endif
    end
  end

  // Buffer entries, single write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_ENTRIES); i++) ent_q[i] <= '0;
    end else if (ent_we) begin
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
        if (ent_sel == 1'(i)) ent_q[i] <= ent_wdata;
      end
    end
  end

  assign bus.core_busy  = !hit;
  assign bus.core_rdata = hit_data;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = {word_addr_q, asm_idx};
  assign bus.fetch_err  = fetch_err_q;

endmodule

// File: tb/tb_fetch_byte_bridge.sv
// Directed testbench for fetch_byte_bridge with a byte-wide memory model
// (programmable wait states, or no ack at all).
module tb_fetch_byte_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;
  int   wait_states = 0;
  bit   no_ack = 1'b0;
  int   wcnt = 0;

  fetch_byte_bridge_if bus ();

  fetch_byte_bridge #(.TIMEOUT(8), .NOP_WORD(32'h0000_0013)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Word 0 holds 13,05,50,00; every other byte is its address low byte XOR A5.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [7:0] b;
    if (a[31:2] == 30'd0) begin
      case (a[1:0])
        2'd0:    b = 8'h13;
        2'd1:    b = 8'h05;
        2'd2:    b = 8'h50;
        default: b = 8'h00;
      endcase
    end else begin
      b = a[7:0] ^ 8'hA5;
    end
    return b;
  endfunction

  assign bus.mem_rdata = mem_byte(bus.mem_addr);
  assign bus.mem_ack   = bus.mem_req && !no_ack && (wcnt >= wait_states);

  always @(posedge clk) begin
    if (!bus.mem_req || bus.mem_ack) wcnt <= 0;
    else                             wcnt <= wcnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_not_busy(input int limit, output int n);
    n = 0;
    while (bus.core_busy === 1'b1 && n < limit) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.core_addr = 32'h0;
    wait_states = 0;
    no_ack = 1'b0;
    step();
    step();
    n_total++; if (bus.mem_req !== 1'b0) $display("FAIL reset_mem_req got %b want 0", bus.mem_req); else n_pass++;
    n_total++; if (bus.mem_addr !== 32'h0) $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr); else n_pass++;
    n_total++; if (bus.core_rdata !== 32'h0) $display("FAIL reset_core_rdata got %h want 0", bus.core_rdata); else n_pass++;
    n_total++; if (bus.core_busy !== 1'b1) $display("FAIL reset_core_busy got %b want 1", bus.core_busy); else n_pass++;
    n_total++; if (bus.fetch_err !== 1'b0) $display("FAIL reset_fetch_err got %b want 0", bus.fetch_err); else n_pass++;
  endtask

  task automatic test_zero_wait();
    logic [31:0] addrs [4];
    int cyc;
    int k;
    bit stable;
    rst = 1'b0;
    #1;
    cyc = 1;
    k = 0;
    while (bus.core_busy === 1'b1 && cyc < 20) begin
      if (bus.mem_req && bus.mem_ack) begin
        if (k < 4) addrs[k] = bus.mem_addr;
        k++;
      end
      step();
      cyc++;
    end
    n_total++; if (k !== 4) $display("FAIL zw_ack_count got %0d want 4", k); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (k > i && addrs[i] === 32'(i)) n_pass++;
      else $display("FAIL zw_mem_addr%0d got %h want %h", i, addrs[i], 32'(i));
    end
    n_total++; if (cyc !== 6) $display("FAIL zw_busy_low_cycle got %0d want 6", cyc); else n_pass++;
    n_total++; if (bus.core_rdata !== 32'h0050_0513) $display("FAIL zw_rdata got %h want 00500513", bus.core_rdata); else n_pass++;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.core_busy !== 1'b0 || bus.mem_req !== 1'b0 || bus.core_rdata !== 32'h0050_0513) stable = 1'b0;
    end
    n_total++; if (stable !== 1'b1) $display("FAIL zw_hold_hit got %b want 1", stable); else n_pass++;
  endtask

  task automatic test_wait_states();
    logic [31:0] addrs [4];
    int cyc;
    int k;
    bit req_held;
    wait_states = 3;
    bus.core_addr = 32'h0000_0104;
    #1;
    cyc = 0;
    k = 0;
    req_held = 1'b1;
    while (bus.core_busy === 1'b1 && cyc < 60) begin
      if (cyc > 0 && bus.mem_req !== 1'b1) req_held = 1'b0;
      if (bus.mem_req && bus.mem_ack) begin
        if (k < 4) addrs[k] = bus.mem_addr;
        k++;
      end
      step();
      cyc++;
    end
    n_total++; if (req_held !== 1'b1) $display("FAIL ws_req_held got %b want 1", req_held); else n_pass++;
    n_total++; if (k !== 4) $display("FAIL ws_ack_count got %0d want 4", k); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (k > i && addrs[i] === 32'h104 + 32'(i)) n_pass++;
      else $display("FAIL ws_mem_addr%0d got %h want %h", i, addrs[i], 32'h104 + 32'(i));
    end
    n_total++; if (cyc !== 17) $display("FAIL ws_busy_after_last_ack got %0d want 17", cyc); else n_pass++;
    n_total++; if (bus.core_rdata !== 32'hA2A3_A0A1) $display("FAIL ws_rdata got %h want a2a3a0a1", bus.core_rdata); else n_pass++;
    wait_states = 0;
  endtask

  task automatic test_timeout();
    int cyc;
    int stalls;
    int n;
    no_ack = 1'b1;
    bus.core_addr = 32'h0000_0300;
    #1;
    cyc = 0;
    stalls = 0;
    while (bus.core_busy === 1'b1 && cyc < 40) begin
      if (bus.mem_req === 1'b1) stalls++;
      step();
      cyc++;
    end
    n_total++; if (stalls !== 8) $display("FAIL to_stall_cycles got %0d want 8", stalls); else n_pass++;
    n_total++; if (bus.core_busy !== 1'b0) $display("FAIL to_busy got %b want 0", bus.core_busy); else n_pass++;
    n_total++; if (bus.core_rdata !== 32'h0000_0013) $display("FAIL to_rdata got %h want 00000013", bus.core_rdata); else n_pass++;
    n_total++; if (bus.fetch_err !== 1'b1) $display("FAIL to_fetch_err got %b want 1", bus.fetch_err); else n_pass++;
    n_total++; if (bus.mem_req !== 1'b0) $display("FAIL to_req_drop got %b want 0", bus.mem_req); else n_pass++;
    no_ack = 1'b0;
    bus.core_addr = 32'h0000_0104;
    #1;
    wait_not_busy(40, n);
    n_total++; if (bus.core_rdata !== 32'hA2A3_A0A1) $display("FAIL to_refill_rdata got %h want a2a3a0a1", bus.core_rdata); else n_pass++;
    n_total++; if (bus.fetch_err !== 1'b1) $display("FAIL to_err_sticky got %b want 1", bus.fetch_err); else n_pass++;
    rst = 1'b1;
    step();
    n_total++; if (bus.fetch_err !== 1'b0) $display("FAIL to_err_cleared got %b want 0", bus.fetch_err); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_alternate();
    logic [31:0] addr_tab [4];
    logic [31:0] exp_tab [4];
    int n;
    addr_tab = '{32'h20, 32'h0, 32'h20, 32'h0};
    exp_tab  = '{32'h8687_8485, 32'h0050_0513, 32'h8687_8485, 32'h0050_0513};
    for (int i = 0; i < 4; i++) begin
      bus.core_addr = addr_tab[i];
      #1;
      n_total++; if (bus.core_busy !== 1'b1) $display("FAIL alt%0d_miss got %b want 1", i, bus.core_busy); else n_pass++;
      wait_not_busy(30, n);
      n_total++; if (n !== 5) $display("FAIL alt%0d_latency got %0d want 5", i, n); else n_pass++;
      n_total++; if (bus.core_rdata !== exp_tab[i]) $display("FAIL alt%0d_rdata got %h want %h", i, bus.core_rdata, exp_tab[i]); else n_pass++;
      step();
    end
  endtask

  task automatic test_reset_mid_fill();
    bit found;
    int n;
    bus.core_addr = 32'h0000_0104;
    #1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.mem_req === 1'b1 && bus.mem_addr[1:0] === 2'd2) found = 1'b1;
      else step();
    end
    n_total++; if (found !== 1'b1) $display("FAIL rmf_reach_idx2 got %b want 1", found); else n_pass++;
    rst = 1'b1;
    step();
    n_total++; if (bus.mem_req !== 1'b0) $display("FAIL rmf_req_drop got %b want 0", bus.mem_req); else n_pass++;
    n_total++; if (bus.core_busy !== 1'b1) $display("FAIL rmf_busy got %b want 1", bus.core_busy); else n_pass++;
    rst = 1'b0;
    n = 0;
    while (bus.mem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    n_total++; if (bus.mem_addr !== 32'h0000_0104) $display("FAIL rmf_restart_idx0 got %h want 00000104", bus.mem_addr); else n_pass++;
    wait_not_busy(30, n);
    n_total++; if (bus.core_rdata !== 32'hA2A3_A0A1) $display("FAIL rmf_rdata got %h want a2a3a0a1", bus.core_rdata); else n_pass++;
  endtask

`ifdef NEXT_WORD_PREFETCH_EN
  task automatic test_prefetch();
    logic [31:0] first_addr;
    int n;
    int k;
    bit done;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.core_addr = 32'hFFFF_FFFC;
    #1;
    wait_not_busy(30, n);
    n_total++; if (bus.core_rdata !== 32'h5A5B_5859) $display("FAIL pf_top_rdata got %h want 5a5b5859", bus.core_rdata); else n_pass++;
    k = 0;
    done = 1'b0;
    first_addr = 32'hDEAD_BEEF;
    for (int i = 0; i < 30 && !done; i++) begin
      if (bus.mem_req && bus.mem_ack) begin
        if (k == 0) first_addr = bus.mem_addr;
        k++;
      end
      if (k == 4 && bus.mem_req === 1'b0) done = 1'b1;
      else step();
    end
    n_total++; if (k !== 4) $display("FAIL pf_byte_count got %0d want 4", k); else n_pass++;
    n_total++; if (first_addr !== 32'h0) $display("FAIL pf_wrap_addr got %h want 0", first_addr); else n_pass++;
    bus.core_addr = 32'h0;
    #1;
    n_total++; if (bus.core_busy !== 1'b0) $display("FAIL pf_hit_busy got %b want 0", bus.core_busy); else n_pass++;
    n_total++; if (bus.core_rdata !== 32'h0050_0513) $display("FAIL pf_hit_rdata got %h want 00500513", bus.core_rdata); else n_pass++;
    n_total++; if (bus.mem_req !== 1'b0) $display("FAIL pf_hit_no_req got %b want 0", bus.mem_req); else n_pass++;
  endtask
`endif

  initial begin
    bus.core_addr = 32'h0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_timeout();
    test_alternate();
    test_reset_mid_fill();
`ifdef NEXT_WORD_PREFETCH_EN
    test_prefetch();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
